fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the control/decode block. It holds the PC and issues one request at a time to instruction memory over a req/ack handshake. The returned word is latched into an instruction register that drives the decoder's 32-bit instruction input. The block supports stall, branch redirect and a halt word.

Parameters:
PC_WIDTH, 32, width of PC and memory address.
PC_RESET, 32'h0000_0000, PC value loaded on reset.
HALT_WORD, 32'hFFFF_FFFF, instruction word that stops fetching.

Ports:
CLK  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  downstream not ready; holds the current instruction.
branch_taken  in  1  redirect for the instruction currently presented.
branch_target  in  PC_WIDTH  redirect address.
imem_req  out  1  memory request.
imem_addr  out  PC_WIDTH  request address.
imem_ack  in  1  memory data valid this cycle.
imem_rdata  in  32  memory data.
instr  out  32  instruction register; feeds the decoder.
instr_valid  out  1  instr holds a live instruction.
instr_pc  out  PC_WIDTH  address of instr.
halted  out  1  HALT_WORD reached.

Behaviour:
- Reset (asynchronous, active-high) takes effect immediately, including mid-request:
  - pc=PC_RESET, instr=0, instr_pc=0, instr_valid=0, imem_req=0, halted=0, state=IDLE.
  - An in-flight request is abandoned.
  - An ack arriving during or after reset is ignored.
- FSM states: IDLE, FETCH, VALID, HALT.
- IDLE: imem_req=0. Go to FETCH on the next edge.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - imem_ack is sampled on the rising edge. Ack in the first FETCH cycle is legal (zero-wait memory).
  - On ack: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1.
  - On ack, go to HALT if imem_rdata==HALT_WORD, else to VALID.
- VALID:
  - imem_req=0. instr and instr_valid are held.
  - stall=1: hold everything. branch_taken is ignored while stalled.
  - stall=0: the instruction is consumed. instr_valid<=0 and go to FETCH.
  - stall=0 and branch_taken=1: additionally pc<=branch_target with bits[1:0] forced to 0.
- HALT:
  - instr_valid=1 with instr=HALT_WORD.
  - halted=1 from the cycle after the ack.
  - imem_req=0. Stall and branch inputs are ignored. Only reset exits.
- Outside FETCH: imem_ack is ignored, and branch_taken is ignored in every state other than VALID.
- PC arithmetic is modulo 2^PC_WIDTH: pc+4 at the top address wraps to 0.
- Steady-state throughput (zero-wait memory, no stall): one instruction every 2 cycles.
- Latency: request asserted to instr_valid is ack cycle + 1 edge.
- Exactly one outstanding request at any time. imem_req never drops before ack except on reset.

Test Plan:
1. Reset then zero-wait memory returning 32'h38224002 (LW), 32'h3C220000 (SW), 32'h34221AA0 (ADD) -> imem_addr 0,4,8; instr matches each word; instr_pc 0,4,8; instr_valid high one cycle per 2-cycle period.
2. Memory acks 3 cycles late -> imem_req and imem_addr stable for all wait cycles; exactly one capture; pc advances by exactly 4.
3. stall=1 for 5 cycles while VALID holding ADD -> instr stays 32'h34221AA0; no imem_req; fetch of pc+4 starts the cycle after stall drops.
4. branch_taken=1, branch_target=32'h0000_0103, stall=0 in VALID -> next imem_addr=32'h0000_0100. The same branch with stall=1 is ignored.
5. PC_RESET=32'hFFFF_FFFC -> second fetch address is 0. Memory returns 32'hFFFF_FFFF -> halted=1, no further requests until reset.
6. rst asserted mid-FETCH with ack pending -> imem_req drops asynchronously; instr=0, instr_valid=0; after release, first request goes to PC_RESET.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and runs one req/ack fetch at a time.
// The captured word feeds the decoder until it is consumed; a halt word parks the unit.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] PC_RESET  = '0,
  parameter logic [31:0]         HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    HALT
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_n;
  logic [PC_WIDTH-1:0] instr_pc_n;
  logic [31:0]         instr_n;
  logic                valid_n;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= PC_RESET;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    valid_n    = instr_valid;
    imem_req   = 1'b0;
    halted     = 1'b0;
    unique case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_n    = imem_rdata;
          instr_pc_n = pc;
          pc_n       = pc + PC_WIDTH'(4);
          valid_n    = 1'b1;
          state_n    = (imem_rdata == HALT_WORD) ? HALT : VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          valid_n = 1'b0;
          state_n = FETCH;
          // redirect targets are word aligned
          if (branch_taken)
            pc_n = branch_target & ~PC_WIDTH'(3);
        end
      end
      HALT: halted = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  // pc only moves on ack or consume, so the address is stable while waiting
  assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a memory/consumer driver
// predicts the fetch stream, a monitor checks what the decoder sees.
module tb_fetch_unit;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        halted;

  logic        rst2 = 1'b1;
  logic        req2;
  logic        ack2;
  logic [31:0] addr2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic        valid2;
  logic [31:0] ipc2;
  logic        halted2;

  fetch_unit dut (
    .CLK(CLK), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .instr_pc(instr_pc), .halted(halted)
  );

  fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .rst(rst2), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2),
    .instr(instr2), .instr_valid(valid2),
    .instr_pc(ipc2), .halted(halted2)
  );

  assign ack2   = req2;
  assign rdata2 = (addr2 == 32'h0) ? HW : 32'h0000_0013;

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] dir_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc = '0;
  bit          auto_en = 1'b1;
  bit          force_halt = 1'b0;
  bit          busy = 1'b0;
  bit          expect_req = 1'b0;
  int          waited = 0;
  int          lat = 0;
  int          n_fetched = 0;
  int          n_consumed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[15:0], a[31:16]} ^ 32'h5A5A_1234 ^ (a << 3);
    if (w == HW) w = 32'h0000_0013;
    return w;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 2))
      0: return 32'h0000_0103;
      1: return 32'hFFFF_FFFD;
      default: return $urandom;
    endcase
  endfunction

  // memory + consumer driver; also owns the expected fetch address
  always @(negedge CLK) begin
    if (auto_en && !rst) begin
      imem_ack = 1'b0;
      if (expect_req) begin
        chk("fetch_after_consume", imem_req, 1'b1);
        expect_req = 1'b0;
      end
      if (imem_req) begin
        if (!busy) begin
          busy   = 1'b1;
          waited = 0;
          lat    = (dir_q.size() != 0) ? 0 : $urandom_range(0, 3);
        end
        chk("imem_addr", imem_addr, exp_pc);
        if (waited == lat) begin
          imem_ack = 1'b1;
          if (dir_q.size() != 0) imem_rdata = dir_q.pop_front();
          else if (force_halt)   imem_rdata = HW;
          else                   imem_rdata = word(imem_addr);
          sbq.push_back({imem_rdata, exp_pc});
          exp_pc = exp_pc + 32'd4;
          busy = 1'b0;
          n_fetched++;
        end else begin
          waited++;
        end
      end else begin
        imem_ack   = ($urandom_range(0, 3) == 0);
        imem_rdata = $urandom;
      end
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = pick_target();
      if (halted) begin
        stall        = $urandom_range(0, 1) == 1;
        branch_taken = $urandom_range(0, 1) == 1;
      end else if (instr_valid) begin
        if (n_consumed >= 3) begin
          stall        = ($urandom_range(0, 2) == 0);
          branch_taken = ($urandom_range(0, 3) == 0);
        end
        if (!stall) begin
          n_consumed++;
          expect_req = 1'b1;
          if (branch_taken) exp_pc = branch_target & ~32'd3;
        end
      end
    end
  end

  // monitor: one scoreboard entry per valid window
  exp_t cur = '0;
  bit   prev_v = 1'b0;
  always @(negedge CLK) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (instr_valid && !prev_v) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr actual=%h required=none", instr);
        end else begin
          cur = sbq.pop_front();
        end
      end
      if (instr_valid) begin
        chk("instr", instr, cur.ins);
        chk("instr_pc", instr_pc, cur.pc);
        chk("req_while_valid", imem_req, 1'b0);
      end
      prev_v = instr_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] dir_w[3];
    dir_w[0] = 32'h3822_4002;
    dir_w[1] = 32'h3C22_0000;
    dir_w[2] = 32'h3422_1AA0;
    for (int k = 0; k < 3; k++) dir_q.push_back(dir_w[k]);
    repeat (2) @(negedge CLK);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst2_req", req2, 1'b0);
    rst  = 1'b0;
    rst2 = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("valid_cadence", instr_valid, 32'(i % 2));
      if (i % 2 == 0) chk("dir_addr", imem_addr, 32'(i * 2));
      else            chk("dir_instr", instr, dir_w[i / 2]);
      if (i == 0) chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
      if (i == 1) chk("wrap_instr_pc", ipc2, 32'hFFFF_FFFC);
      if (i == 2) chk("wrap_second_addr", addr2, 32'h0);
      if (i >= 3) begin
        chk("wrap_halted", halted2, 1'b1);
        chk("wrap_no_req", req2, 1'b0);
      end
    end

    cyc = 0;
    while (n_fetched < 60 && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
    end
    chk("random_phase_done", 32'(n_fetched >= 60), 32'd1);

    force_halt = 1'b1;
    cyc = 0;
    while (!halted && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    chk("halt_reached", halted, 1'b1);
    repeat (10) begin
      @(negedge CLK);
      chk("halt_no_req", imem_req, 1'b0);
      chk("halt_instr", instr, HW);
      chk("halt_valid", instr_valid, 1'b1);
    end

    auto_en    = 1'b0;
    force_halt = 1'b0;
    imem_ack   = 1'b0;
    rst        = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    chk("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, 32'h0);
    repeat (2) @(negedge CLK);
    #2 rst = 1'b1;
    #1;
    chk("async_req_drop", imem_req, 1'b0);
    chk("async_instr", instr, 32'h0);
    chk("async_valid", instr_valid, 1'b0);
    chk("async_halted", halted, 1'b0);
    @(negedge CLK);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    imem_ack = 1'b0;
    chk("ack_in_reset_ignored", instr_valid, 1'b0);
    sbq.delete();
    exp_pc     = 32'h0;
    busy       = 1'b0;
    expect_req = 1'b0;
    n_fetched  = 0;
    rst        = 1'b0;
    auto_en    = 1'b1;

    cyc = 0;
    while (n_fetched < 10 && cyc < 500) begin
      @(negedge CLK);
      cyc++;
    end
    chk("restart_phase_done", 32'(n_fetched >= 10), 32'd1);
    repeat (12) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
